// File: rtl/os_systolic_array_if.sv
// Load and drain handshake bundle for the output-stationary MAC array.
// Master is the buffer side, slave is the array.
interface os_systolic_array_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic                    relu_en;
  logic [ROWS*WIDTH-1:0]   a_in;
  logic [COLS*WIDTH-1:0]   b_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [COLS*WIDTH-1:0]   out_data;
  logic                    out_last;
  logic                    busy;

  modport master (
    output in_valid, in_last, relu_en, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_last, relu_en, a_in, b_in, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/os_systolic_array.sv
// Output-stationary ROWSxCOLS fixed-point MAC array with input skew,
// sequencer FSM and saturating/ReLU row-by-row drain.
module os_systolic_array #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ACC_W = 40
) (
  input logic              clk,
  input logic              rst,
  os_systolic_array_if.slave io
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  localparam int N  = ROWS + COLS - 1;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [ACC_W-1:0] MAXV =
    ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic            busy_q;
  logic            relu_q;
  logic            beat;
  logic            fin;

  assign beat = io.in_valid & in_ready_q;
  assign fin  = out_valid_q & io.out_ready
              & (idx == IW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      relu_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (beat) begin
          relu_q <= io.relu_en;
          busy_q <= 1'b1;
          if (io.in_last) begin
            state      <= FLUSH;
            cnt        <= CW'(N - 1);
            in_ready_q <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: if (beat && io.in_last) begin
          state      <= FLUSH;
          cnt        <= CW'(N - 1);
          in_ready_q <= 1'b0;
        end
        FLUSH: if (cnt == '0) begin
          state       <= DRAIN;
          idx         <= '0;
          out_valid_q <= 1'b1;
          out_last_q  <= (ROWS == 1);
        end else begin
          cnt <= cnt - 1'b1;
        end
        DRAIN: if (io.out_ready) begin
          if (idx == IW'(ROWS - 1)) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            idx        <= idx + 1'b1;
            out_last_q <= (idx == IW'(ROWS - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [WIDTH-1:0] a_w [ROWS];
  logic signed [WIDTH-1:0] b_n [COLS];
  logic signed [ACC_W-1:0] acc [ROWS][COLS];

  // lane r of A sits r cycles longer so its wavefront meets B's
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [WIDTH-1:0] d [r+1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j <= r; j++) d[j] <= '0;
      end else begin
        d[0] <= beat ? io.a_in[r*WIDTH +: WIDTH] : '0;
        for (int j = 1; j <= r; j++) d[j] <= d[j-1];
      end
    end
    assign a_w[r] = d[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [WIDTH-1:0] d [c+1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j <= c; j++) d[j] <= '0;
      end else begin
        d[0] <= beat ? io.b_in[c*WIDTH +: WIDTH] : '0;
        for (int j = 1; j <= c; j++) d[j] <= d[j-1];
      end
    end
    assign b_n[c] = d[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [WIDTH-1:0]   a_op;
      logic signed [WIDTH-1:0]   b_op;
      logic signed [2*WIDTH-1:0] p;
      logic signed [2*WIDTH-1:0] sh;
      logic signed [ACC_W-1:0]   ext;

      if (c == 0) begin : g_aw
        assign a_op = a_w[r];
      end else begin : g_ai
        assign a_op = g_row[r].g_col[c-1].g_fa.q;
      end

      if (r == 0) begin : g_bn
        assign b_op = b_n[c];
      end else begin : g_bi
        assign b_op = g_row[r-1].g_col[c].g_fb.q;
      end

      if (c < COLS - 1) begin : g_fa
        logic signed [WIDTH-1:0] q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) q <= '0;
          else      q <= a_op;
        end
      end

      if (r < ROWS - 1) begin : g_fb
        logic signed [WIDTH-1:0] q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) q <= '0;
          else      q <= b_op;
        end
      end

      assign p   = (2*WIDTH)'(a_op) * (2*WIDTH)'(b_op);
      assign sh  = p >>> FRAC;
      assign ext = ACC_W'(sh);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     acc[r][c] <= '0;
        else if (fin) acc[r][c] <= '0;
        else          acc[r][c] <= acc[r][c] + ext;
      end
    end
  end

  function automatic logic [WIDTH-1:0] clamp(
    input logic signed [ACC_W-1:0] v,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] s;
    if (v > MAXV)      s = MAXV;
    else if (v < MINV) s = MINV;
    else               s = v;
    if (relu && s < 0) s = '0;
    return s[WIDTH-1:0];
  endfunction

  logic [COLS*WIDTH-1:0] data;

  always_comb begin
    data = '0;
    for (int c = 0; c < COLS; c++)
      data[c*WIDTH +: WIDTH] = clamp(acc[idx][c], relu_q);
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.out_data  = data;
  assign io.busy      = busy_q;

endmodule

// File: tb/tb_os_systolic_array.sv
// Directed bench for os_systolic_array: 4x4 and 2x6 instances,
// hand-computed tiles, stall, bubble and mid-drain reset cases.
module tb_os_systolic_array;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  os_systolic_array_if #(.WIDTH(16), .ROWS(4), .COLS(4)) io4 ();
  os_systolic_array_if #(.WIDTH(16), .ROWS(2), .COLS(6)) io26 ();

  os_systolic_array #(
    .WIDTH(16), .FRAC(8), .ROWS(4), .COLS(4), .ACC_W(40)
  ) dut4 (
    .clk(clk), .rst(rst), .io(io4.slave)
  );

  os_systolic_array #(
    .WIDTH(16), .FRAC(8), .ROWS(2), .COLS(6), .ACC_W(40)
  ) dut26 (
    .clk(clk), .rst(rst), .io(io26.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] av [4];
  logic [15:0] bv [4];
  logic [15:0] ex [4][4];
  logic [15:0] av2 [2];
  logic [15:0] bv2 [6];
  logic [15:0] ex2 [2][6];

  task automatic push(input logic last, input logic relu);
    chk("push_rdy", 64'(io4.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      io4.a_in[i*16 +: 16] = av[i];
      io4.b_in[i*16 +: 16] = bv[i];
    end
    io4.in_valid = 1'b1;
    io4.in_last  = last;
    io4.relu_en  = relu;
    @(negedge clk);
    io4.in_valid = 1'b0;
    io4.in_last  = 1'b0;
    io4.relu_en  = 1'b0;
    io4.a_in     = '1;
    io4.b_in     = '1;
  endtask

  task automatic row4(input int i, input string tag);
    chk($sformatf("%s_vld%0d", tag, i), 64'(io4.out_valid), 64'd1);
    chk($sformatf("%s_irdy%0d", tag, i), 64'(io4.in_ready), 64'd0);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s_r%0dc%0d", tag, i, c),
          64'(io4.out_data[c*16 +: 16]), 64'(ex[i][c]));
    chk($sformatf("%s_last%0d", tag, i),
        64'(io4.out_last), 64'(i == 3));
  endtask

  task automatic drain4(input int stall, input string tag);
    int n = 0;
    io4.out_ready = 1'b0;
    while (!io4.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, 64'(io4.out_valid), 64'd1);
    repeat (stall) begin
      row4(0, {tag, "_stall"});
      @(negedge clk);
    end
    io4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      row4(i, tag);
      @(negedge clk);
    end
    io4.out_ready = 1'b0;
    chk({tag, "_end_vld"}, 64'(io4.out_valid), 64'd0);
    chk({tag, "_end_rdy"}, 64'(io4.in_ready), 64'd1);
    chk({tag, "_end_busy"}, 64'(io4.busy), 64'd0);
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] e);
    for (int i = 0; i < 4; i++) begin
      av[i] = a;
      bv[i] = b;
      for (int c = 0; c < 4; c++) ex[i][c] = e;
    end
  endtask

  task automatic push26(input logic last);
    for (int i = 0; i < 2; i++) io26.a_in[i*16 +: 16] = av2[i];
    for (int i = 0; i < 6; i++) io26.b_in[i*16 +: 16] = bv2[i];
    io26.in_valid = 1'b1;
    io26.in_last  = last;
    @(negedge clk);
    io26.in_valid = 1'b0;
    io26.in_last  = 1'b0;
    io26.a_in     = '1;
    io26.b_in     = '1;
  endtask

  task automatic drain26();
    int n = 0;
    while (!io26.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w26_wait", 64'(io26.out_valid), 64'd1);
    io26.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w26_vld%0d", i), 64'(io26.out_valid), 64'd1);
      for (int c = 0; c < 6; c++)
        chk($sformatf("w26_r%0dc%0d", i, c),
            64'(io26.out_data[c*16 +: 16]), 64'(ex2[i][c]));
      chk($sformatf("w26_last%0d", i), 64'(io26.out_last), 64'(i == 1));
      @(negedge clk);
    end
    io26.out_ready = 1'b0;
    chk("w26_end_vld", 64'(io26.out_valid), 64'd0);
  endtask

  initial begin
    int n;
    io4.in_valid   = 1'b0;
    io4.in_last    = 1'b0;
    io4.relu_en    = 1'b0;
    io4.a_in       = '0;
    io4.b_in       = '0;
    io4.out_ready  = 1'b0;
    io26.in_valid  = 1'b0;
    io26.in_last   = 1'b0;
    io26.relu_en   = 1'b0;
    io26.a_in      = '0;
    io26.b_in      = '0;
    io26.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(io4.in_ready), 64'd1);
    chk("rst_vld", 64'(io4.out_valid), 64'd0);
    chk("rst_last", 64'(io4.out_last), 64'd0);
    chk("rst_data", 64'(io4.out_data), 64'd0);
    chk("rst_busy", 64'(io4.busy), 64'd0);

    // identity A against B rows, with a 5-cycle stall on row 0
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        av[i] = (i == k) ? 16'h0100 : 16'h0000;
        bv[i] = 16'(16'h0100 * (k * 4 + i + 1));
      end
      push(k == 3, 1'b0);
    end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++)
        ex[i][c] = 16'(16'h0100 * (i * 4 + c + 1));
    drain4(5, "ident");

    // single slice: 2.0 * 1.5 = 3.0, out_valid exactly 7 edges later
    fill(16'h0200, 16'h0180, 16'h0300);
    push(1'b1, 1'b0);
    n = 0;
    while (!io4.out_valid && n < 20) begin
      chk("one_flush_rdy", 64'(io4.in_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("one_lat", 64'(n), 64'd7);
    drain4(0, "one");

    // positive and negative saturation, then ReLU on the negative case
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int k = 0; k < 4; k++) push(k == 3, 1'b0);
    drain4(0, "satp");
    fill(16'h7FFF, 16'h8000, 16'h8000);
    for (int k = 0; k < 4; k++) push(k == 3, 1'b0);
    drain4(0, "satn");
    fill(16'h7FFF, 16'h8000, 16'h0000);
    for (int k = 0; k < 4; k++) push(k == 3, k == 0);
    drain4(0, "relu");

    // K=3 with bubbles (1,0,0,1,0,1), then the same slices contiguous
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++)
        ex[i][c] = 16'(16'h0100 * (c + 1) * (3 * i + 6));
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        av[i] = 16'(16'h0100 * (i + k + 1));
        bv[i] = 16'(16'h0100 * (i + 1));
      end
      push(k == 2, 1'b0);
      if (k == 0) repeat (2) @(negedge clk);
      if (k == 1) @(negedge clk);
    end
    drain4(0, "gap");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        av[i] = 16'(16'h0100 * (i + k + 1));
        bv[i] = 16'(16'h0100 * (i + 1));
      end
      push(k == 2, 1'b0);
    end
    drain4(0, "contig");

    // 2x6 instance: identity A reproduces the B rows
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) av2[i] = (i == k) ? 16'h0100 : 16'h0000;
      for (int c = 0; c < 6; c++) bv2[c] = 16'(16'h0100 * (k * 6 + c + 1));
      push26(k == 1);
    end
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 6; c++)
        ex2[i][c] = 16'(16'h0100 * (i * 6 + c + 1));
    drain26();

    // reset after row 1 of a drain, then a clean tile
    fill(16'h0200, 16'h0180, 16'h0300);
    push(1'b1, 1'b0);
    n = 0;
    while (!io4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ab_wait", 64'(io4.out_valid), 64'd1);
    io4.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    io4.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("ab_vld", 64'(io4.out_valid), 64'd0);
    chk("ab_rdy", 64'(io4.in_ready), 64'd1);
    chk("ab_busy", 64'(io4.busy), 64'd0);
    chk("ab_data", 64'(io4.out_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(1'b1, 1'b0);
    drain4(0, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/os_systolic_array.md
# os_systolic_array

Parametrised output-stationary systolic MAC array computing one ROWS×COLS fixed-point tile C = A·B over a streamed K dimension. It has built-in input skew, a valid/ready load handshake, a sequencer FSM, saturating/ReLU output and a row-by-row drain handshake. It sits between the feature/weight buffers and the output buffer in the CNN datapath, replacing externally sequenced fixed-4×4 arrays.

## Interface
- WIDTH, 16: operand/result width, signed two's complement
- FRAC, 8: fractional bits (Q(WIDTH-FRAC).FRAC)
- ROWS, 4: array rows (A lanes, output rows), ≥1
- COLS, 4: array columns (B lanes, output columns), ≥1
- ACC_W, 40: accumulator width, ≥2*WIDTH
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  k-slice present on a_in/b_in
- in_ready  out  1  array accepts slice
- in_last  in  1  qualifies final slice of tile
- relu_en  in  1  sampled with first slice of tile; negative results output as 0
- a_in  in  ROWS*WIDTH  A column slice, lane r at [r*WIDTH +: WIDTH]
- b_in  in  COLS*WIDTH  B row slice, lane c at [c*WIDTH +: WIDTH]
- out_valid  out  1  out_data holds one result row
- out_ready  in  1  consumer takes row
- out_data  out  COLS*WIDTH  result row, column c at [c*WIDTH +: WIDTH]
- out_last  out  1  current row is row ROWS-1
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN; reset → IDLE, all accumulators, skew registers, counters, latched relu_en = 0.
- in_ready = 1 in IDLE and LOAD, 0 in FLUSH/DRAIN. Beat = in_valid & in_ready.
- IDLE: beat without in_last → LOAD; beat with in_last → FLUSH (single-slice tile). relu_en latched on first beat.
- LOAD: beat with in_last → FLUSH; in_valid gaps allowed (bubbles inject zero operands, result unaffected).
- FLUSH: down-counter of ROWS+COLS-1 cycles; on expiry → DRAIN, row index 0.
- DRAIN: out_valid = 1, out_data = row[idx]; on out_valid & out_ready idx++; handshake on idx = ROWS-1 → clear all accumulators, → IDLE.
- Datapath: a_in/b_in registered once; lane r of A delayed r extra cycles, lane c of B delayed c; A moves right one PE per cycle, B moves down one PE per cycle; invalid slices enter as 0.
- PE(r,c): p = a*b (signed 2*WIDTH), p >>> FRAC (arithmetic, truncate toward −∞), sign-extend to ACC_W, acc += p (wraps mod 2^ACC_W).
- Output: sat = clamp(acc, −2^(WIDTH−1), 2^(WIDTH−1)−1); if latched relu_en and sat < 0 → 0.

## Timing
- Slice k accepted at edge Ek is accumulated in PE(r,c) at edge Ek+1+r+c.
- out_valid first asserts after ROWS+COLS-1 edges following the edge accepting in_last (7 for 4×4); row i of an unstalled drain appears ROWS+COLS-1+i edges after it.
- out_data/out_last stable while out_valid & !out_ready; no combinational path in_valid→in_ready or out_ready→out_valid.
- Earliest next beat: the cycle after the final drain handshake (in_ready=1 in IDLE).
- Reset values: in_ready 1 (IDLE), out_valid 0, out_last 0, out_data 0, busy 0. Reset asserted at any point (mid-LOAD/FLUSH/DRAIN) aborts the tile; the next tile computes from zero.

## Test plan
- 4×4, K=4, A = identity (0x0100 on diagonal), B rows = 0x0100·(r*4+c+1) → out rows equal B rows; out_last only on row 3.
- Single slice with in_last, all a=0x0200, b=0x0180 → all outputs 0x0300; out_valid after exactly 7 edges; in_ready 0 through FLUSH/DRAIN.
- K=4, a=b=0x7FFF → all 0x7FFF; a=0x7FFF, b=0x8000 → 0x8000; same with relu_en=1 → 0x0000.
- Hold out_ready=0 five cycles in DRAIN → row 0 data stable, idx not advanced; then out_ready=1 → rows 1–3 on consecutive cycles.
- K=3 with in_valid toggling 1,0,0,1,0,1 → result identical to contiguous feed; ROWS=2, COLS=6 instance repeats case 1 pattern.
- Assert rst mid-DRAIN (after row 1) → out_valid 0, in_ready 1, busy 0; following tile (case 2) yields 0x0300 everywhere.
